// File: rtl/regfile_write_arbiter_if.sv
// Request-side bundle for regfile_write_arbiter: per-requester valid/lock/addr/data
// with the arbiter's one-hot ready back to the requesters.
interface regfile_write_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_lock;
  logic [6*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with locked bursts for the shared register-file write port.
// Define RF_ARB_PRIO_EN to let requester 0 win every ARB cycle in which it is valid.
module regfile_write_arbiter #(
  parameter int N_REQ    = 3,
  parameter int LOCK_MAX = 4,
  parameter int REG_NUM  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_write_arbiter_if.slave   req_if,
  output logic                     w_enable,
  output logic [5:0]               w_addr,
  output logic [7:0]               w_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_addr,
  output logic                     lock_abort,
  output logic                     busy
);
  localparam int IW = $clog2(N_REQ);

  typedef logic [IW-1:0] id_t;
  typedef enum logic {ARB, LOCKED} state_e;

  state_e     state_q, state_d;
  id_t        owner_q, owner_d;
  id_t        last_q, last_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;

  logic       w_enable_q, w_enable_d;
  logic [5:0] w_addr_q, w_addr_d;
  logic [7:0] w_data_q, w_data_d;
  id_t        grant_id_q, grant_id_d;
  logic       err_addr_q, err_addr_d;
  logic       lock_abort_q, lock_abort_d;

  id_t        rr_win, win, idx;
  logic       found, accept, in_range;
  logic       sel_valid, sel_lock;
  logic [5:0] sel_addr;
  logic [7:0] sel_data;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin : arb_search
    rr_win = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = id_t'((int'(last_q) + k) % N_REQ);
      if (!found && req_if.req_valid[idx]) begin
        found  = 1'b1;
        rr_win = idx;
      end
    end
`ifdef RF_ARB_PRIO_EN
    if (req_if.req_valid[0]) rr_win = '0;
`endif
  end

  assign win = (state_q == LOCKED) ? owner_q : rr_win;

  always_comb begin : lane_select
    sel_valid = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id_t'(i) == win) begin
        sel_valid = req_if.req_valid[i];
        sel_lock  = req_if.req_lock[i];
        sel_addr  = req_if.req_addr[6*i +: 6];
        sel_data  = req_if.req_data[8*i +: 8];
      end
    end
  end

  assign accept   = (state_q == LOCKED) ? sel_valid : found;
  assign in_range = int'(sel_addr) < REG_NUM;

  always_comb begin : ready_decode
    req_if.req_ready = '0;
    if (accept) req_if.req_ready[win] = 1'b1;
  end

  always_comb begin : fsm_next
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    lock_cnt_d   = lock_cnt_q;
    w_enable_d   = 1'b0;
    err_addr_d   = 1'b0;
    lock_abort_d = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    grant_id_d   = grant_id_q;

    if (accept) begin
      last_d     = win;
      w_addr_d   = sel_addr;
      w_data_d   = sel_data;
      grant_id_d = win;
      w_enable_d = in_range;
      err_addr_d = !in_range;
      if (state_q == ARB) begin
        if (sel_lock && LOCK_MAX > 1) begin
          state_d    = LOCKED;
          owner_d    = win;
          lock_cnt_d = 4'd1;
        end
      end else begin
        lock_cnt_d = lock_cnt_q + 4'd1;
        if (!sel_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (lock_cnt_d == 4'(LOCK_MAX)) begin
          // Forced release: last_d already equals the owner, so it drops to lowest priority.
          state_d      = ARB;
          lock_cnt_d   = '0;
          lock_abort_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      owner_q      <= '0;
      last_q       <= id_t'(N_REQ - 1);
      lock_cnt_q   <= '0;
      w_enable_q   <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      grant_id_q   <= '0;
      err_addr_q   <= 1'b0;
      lock_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      lock_cnt_q   <= lock_cnt_d;
      w_enable_q   <= w_enable_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      grant_id_q   <= grant_id_d;
      err_addr_q   <= err_addr_d;
      lock_abort_q <= lock_abort_d;
    end
  end

  assign w_enable   = w_enable_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign grant_id   = grant_id_q;
  assign err_addr   = err_addr_q;
  assign lock_abort = lock_abort_q;
  assign busy       = (state_q == LOCKED);
endmodule
